// File: rtl/adder_pkg.sv
// Shared constants for the carry-select / carry-lookahead adder.
//   DEFAULT_DATA_WIDTH  : default operand and result width
//   DEFAULT_BLOCK_WIDTH : default width of one carry-lookahead block
//   block_count()       : number of CLA blocks spanning the datapath
package adder_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_BLOCK_WIDTH = 4;

    function automatic int unsigned block_count(input int unsigned data_width,
                                                input int unsigned block_width);
        return data_width / block_width;
    endfunction

endpackage

// File: rtl/cla_select_adder_cla_block.sv
// Purely combinational carry-lookahead adder block.
//   a, b : block operands
//   cin  : block carry-in
//   sum  : block sum
//   cout : block carry-out
module cla_block
    import adder_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
    input  logic [BLOCK_WIDTH-1:0] a,
    input  logic [BLOCK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [BLOCK_WIDTH-1:0] sum,
    output logic                   cout
);

    logic [BLOCK_WIDTH-1:0] g;
    logic [BLOCK_WIDTH-1:0] p;
    logic [BLOCK_WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // AND of propagate bits lo..hi inclusive.
    function automatic logic span_and(input logic [BLOCK_WIDTH-1:0] v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        logic r;
        r = 1'b1;
        for (int unsigned k = lo; k <= hi; k++) begin
            r = r & v[k];
        end
        return r;
    endfunction

    // Every carry is a flat sum of products of g/p/cin; no carry feeds another.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
            c[i+1] = g[i] | (cin & span_and(p, 0, i));
            for (int unsigned j = 0; j < i; j++) begin
                c[i+1] = c[i+1] | (g[j] & span_and(p, j + 1, i));
            end
        end
    end

    assign sum  = p ^ c[BLOCK_WIDTH-1:0];
    assign cout = c[BLOCK_WIDTH];

endmodule

// File: rtl/cla_select_adder.sv
// Registered-output adder: {carry_o, result_o} = operand_A_i + operand_B_i + carry_i.
// Carry-select over carry-lookahead blocks, one-cycle latency.
//   clk_i       : rising-edge clock
//   rst_i       : synchronous active-high reset
//   valid_i     : operands valid this cycle
//   operand_A_i : first addend
//   operand_B_i : second addend (two's complement of subtrahend to subtract)
//   carry_i     : carry into bit 0
//   result_o    : registered sum, low DATA_WIDTH bits
//   carry_o     : registered carry out of the MSB
//   valid_o     : result_o/carry_o valid
module cla_select_adder
    import adder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] operand_A_i,
    input  logic [DATA_WIDTH-1:0] operand_B_i,
    input  logic                  carry_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  valid_o
);

    localparam int unsigned N     = block_count(DATA_WIDTH, BLOCK_WIDTH);
    localparam int unsigned SEL_N = (N > 1) ? N - 1 : 1;

    if ((DATA_WIDTH % BLOCK_WIDTH) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("DATA_WIDTH must be a non-zero multiple of BLOCK_WIDTH");
    end

    logic [BLOCK_WIDTH-1:0]            sum_lo;
    logic                              cout_lo;
    // Upper blocks, entry k-1 holds block k: *0 assumes carry-in 0, *1 assumes 1.
    logic [SEL_N-1:0][BLOCK_WIDTH-1:0] sum0;
    logic [SEL_N-1:0][BLOCK_WIDTH-1:0] sum1;
    logic [SEL_N-1:0]                  cout0;
    logic [SEL_N-1:0]                  cout1;

    cla_block #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_cla_lo (
        .a    (operand_A_i[BLOCK_WIDTH-1:0]),
        .b    (operand_B_i[BLOCK_WIDTH-1:0]),
        .cin  (carry_i),
        .sum  (sum_lo),
        .cout (cout_lo)
    );

    for (genvar k = 1; k < N; k++) begin : g_blk
        cla_block #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_cla0 (
            .a    (operand_A_i[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .b    (operand_B_i[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .cin  (1'b0),
            .sum  (sum0[k-1]),
            .cout (cout0[k-1])
        );
        cla_block #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_cla1 (
            .a    (operand_A_i[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .b    (operand_B_i[k*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .cin  (1'b1),
            .sum  (sum1[k-1]),
            .cout (cout1[k-1])
        );
    end

    logic [DATA_WIDTH-1:0] sum_c;
    logic                  chain;

    // Select chain written sequentially so the block carries form no
    // combinational feedback through a shared vector.
    always_comb begin
        sum_c                  = '0;
        sum_c[BLOCK_WIDTH-1:0] = sum_lo;
        chain                  = cout_lo;
        for (int unsigned k = 1; k < N; k++) begin
            sum_c[k*BLOCK_WIDTH +: BLOCK_WIDTH] = chain ? sum1[k-1] : sum0[k-1];
            chain = chain ? cout1[k-1] : cout0[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
            carry_o  <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                result_o <= sum_c;
                carry_o  <= chain;
            end
        end
    end

endmodule

// File: tb/tb_cla_select_adder.sv
// Self-checking bench for cla_select_adder: directed literal vectors plus a
// random regression checked every cycle against a behavioural model.
module tb_cla_select_adder;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;
    logic [31:0] result;
    logic        cout;
    logic        valid_out;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    // Behavioural model of the registered outputs.
    logic [31:0] m_res   = '0;
    logic        m_carry = 1'b0;
    logic        m_valid = 1'b0;

    cla_select_adder #(.DATA_WIDTH(32), .BLOCK_WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_in),
        .operand_A_i (op_a),
        .operand_B_i (op_b),
        .carry_i     (cin),
        .result_o    (result),
        .carry_o     (cout),
        .valid_o     (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic [32:0] full;
        full = {1'b0, op_a} + {1'b0, op_b} + {32'd0, cin};
        if (rst) begin
            m_res   <= '0;
            m_carry <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= valid_in;
            if (valid_in) begin
                m_res   <= full[31:0];
                m_carry <= full[32];
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({valid_out, cout, result} !== {m_valid, m_carry, m_res}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got v=%b c=%b r=%h want v=%b c=%b r=%h",
                         $time, valid_out, cout, result, m_valid, m_carry, m_res);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        @(negedge clk);
        rst      = r;
        valid_in = v;
        op_a     = a;
        op_b     = b;
        cin      = c;
    endtask

    task automatic expect_lit(input string name, input logic v, input logic c,
                              input logic [31:0] r);
        @(posedge clk);
        #1;
        checks++;
        if ({valid_out, cout, result} !== {v, c, r}) begin
            errors++;
            $display("FAIL %s got v=%b c=%b r=%h want v=%b c=%b r=%h",
                     name, valid_out, cout, result, v, c, r);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        rst = 1'b1; valid_in = 1'b1; op_a = '1; op_b = '1; cin = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1;
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_lit("reset", 1'b0, 1'b0, 32'h0);

        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        expect_lit("full_wrap", 1'b1, 1'b1, 32'h0000_0000);
        drive(1'b0, 1'b1, 32'h0000_000F, 32'h0000_0000, 1'b1);
        expect_lit("block_carry_in", 1'b1, 1'b0, 32'h0000_0010);
        drive(1'b0, 1'b1, 32'd5, 32'hFFFF_FFFD, 1'b0);
        expect_lit("sub_no_borrow", 1'b1, 1'b1, 32'h0000_0002);
        drive(1'b0, 1'b1, 32'd3, 32'hFFFF_FFFB, 1'b0);
        expect_lit("sub_borrow", 1'b1, 1'b0, 32'hFFFF_FFFE);
        drive(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        expect_lit("hold", 1'b0, 1'b0, 32'hFFFF_FFFE);
        drive(1'b0, 1'b1, 32'h0FFF_FFFF, 32'h0000_0000, 1'b1);
        expect_lit("long_carry_chain", 1'b1, 1'b0, 32'h1000_0000);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        expect_lit("all_ones_cin", 1'b1, 1'b1, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 32'h8765_4321, 32'h1234_5678, 1'b0);
        expect_lit("mixed", 1'b1, 1'b0, 32'h9999_9999);
        drive(1'b1, 1'b1, 32'h1, 32'h1, 1'b0);
        expect_lit("mid_reset", 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        expect_lit("after_reset", 1'b1, 1'b1, 32'h0000_0000);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            if (i >= 500) rb = ~rb + 32'd1;
            drive((i == 700) ? 1'b1 : 1'b0, 1'b1, ra, rb, rc);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_select_adder.md
# cla_select_adder

Pipelined-output integer adder computing `{carry_o, result_o} = operand_A_i + operand_B_i + carry_i`. Internally it uses a carry-select architecture whose blocks are carry-lookahead adders. It serves as the general-purpose add/subtract datapath element. Subtraction is done by the caller supplying the two's complement of the subtrahend on `operand_B_i`.

## Interface
- `DATA_WIDTH`, default 32: operand/result width in bits.
- `BLOCK_WIDTH`, default 4: width of each carry-lookahead block. `DATA_WIDTH` must be an integer multiple of `BLOCK_WIDTH`; elaboration fails otherwise.

Ports:
- `clk_i` input 1: single clock, rising-edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `valid_i` input 1: operands valid this cycle.
- `operand_A_i` input `DATA_WIDTH`: first addend.
- `operand_B_i` input `DATA_WIDTH`: second addend (two's complement of subtrahend for subtraction).
- `carry_i` input 1: carry-in to bit 0.
- `result_o` output `DATA_WIDTH`: registered sum, low `DATA_WIDTH` bits.
- `carry_o` output 1: registered carry-out of the MSB.
- `valid_o` output 1: `result_o` and `carry_o` are valid.

## Operation
- Arithmetic is unsigned modulo 2^(`DATA_WIDTH`+1): `{carry_o, result_o}` equals the zero-extended `A + B + carry_i`.
- No overflow flag is produced.
- In subtraction usage, `carry_o` = 1 means no borrow (A ≥ B unsigned); `carry_o` = 0 means borrow.
- Block 0 (bits `BLOCK_WIDTH-1:0`) is a single CLA fed by `carry_i`.
- Each block k>0 contains two CLAs, one with carry-in 0 and one with carry-in 1.
  - The carry-out of block k-1 selects that block's sum and carry-out.
  - The block k-1 carry-out is itself the selected (muxed) carry.
- Each CLA block computes per bit g = a&b and p = a^b.
  - Carries: c[i+1] = g[i] | p[i]&c[i], expanded fully in lookahead form within the block (no intra-block ripple).
  - Sum bit = p[i]^c[i].
- Output registers capture the combinational sum when `valid_i`=1. When `valid_i`=0 they hold their previous values.
- `valid_o` is registered from `valid_i`.

## Timing
- Latency is exactly 1 cycle: operands presented with `valid_i`=1 at edge n appear on `result_o`/`carry_o` with `valid_o`=1 after edge n.
- Throughput is one operation per cycle; back-to-back valid inputs are fully supported.
- No backpressure: there is no ready signal, and the downstream stage must accept every `valid_o` pulse.
- Reset (`rst_i`=1 at a rising edge) forces `result_o`=0, `carry_o`=0, `valid_o`=0. Reset overrides `valid_i` asserted in the same cycle.
- Reset mid-stream drops the in-flight result. The first valid input after `rst_i` deasserts produces output one cycle later as normal.
- The combinational path from operands to output registers must settle within one clock period. The critical path is one CLA plus (`DATA_WIDTH`/`BLOCK_WIDTH`-1) 2:1 muxes.

## Structure
- Package `adder_pkg` holds:
  - the default `DATA_WIDTH` and `BLOCK_WIDTH` constants;
  - a `localparam`/function computing the block count `DATA_WIDTH/BLOCK_WIDTH`.
- Sub-module `cla_block` is parameterized by `BLOCK_WIDTH`.
  - Ports: `a`, `b`, `cin` in; `sum`, `cout` out.
  - Purely combinational.
- Top level instantiates `2*N-1` `cla_block` instances in a generate loop, plus the select mux chain and the output register stage.

## Test plan
- Reset: hold `rst_i`=1 with `valid_i`=1, A=B=0xFFFFFFFF -> `result_o`=0, `carry_o`=0, `valid_o`=0.
- Full wrap: A=0xFFFFFFFF, B=0x00000001, `carry_i`=0 -> next cycle `result_o`=0x00000000, `carry_o`=1, `valid_o`=1.
- Block boundary with carry-in: A=0x0000000F, B=0, `carry_i`=1 -> `result_o`=0x00000010, `carry_o`=0.
- Subtraction, no borrow: A=5, B=0xFFFFFFFD (−3) -> `result_o`=0x00000002, `carry_o`=1.
- Subtraction with borrow: A=3, B=0xFFFFFFFB (−5) -> `result_o`=0xFFFFFFFE, `carry_o`=0.
- Random regression: 1000 back-to-back random (A, B, `carry_i`) with `valid_i`=1.
  - First 500 as direct adds; last 500 with B two's-complemented.
  - Insert one `rst_i` pulse mid-stream.
  - Each `{carry_o, result_o}` must equal the 33-bit A+B+`carry_i` one cycle later, except the cycle dropped by reset.
  - Report pass/fail counts.
